// File: rtl/mat_bram_pkg.sv
// rtl/mat_bram_pkg.sv - shared matrix/BRAM types and constants for the BRAM matrix reader and writer
package mat_bram_pkg;

  localparam int ROWS   = 16;
  localparam int COLS   = 128;
  localparam int DW     = 8;
  localparam int RPW    = 4;
  localparam int WORD_W = RPW * COLS * DW;
  localparam int SEL_W  = 6;
  localparam int ADDR_W = 10;
  localparam int NGRP   = ROWS / RPW;
  localparam int GRP_W  = 2;

  typedef logic [0:ROWS-1][0:COLS-1][DW-1:0] mat_t;
  typedef logic [WORD_W-1:0]                 word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } wr_state_t;

  // Slot base is sel*NGRP; upper bits stay zero so a slot never wraps into another.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [SEL_W-1:0] sel,
                                                  input logic [GRP_W-1:0] grp);
    return {{(ADDR_W-SEL_W-GRP_W){1'b0}}, sel, grp};
  endfunction

endpackage

// File: rtl/mat_word_pack.sv
// rtl/mat_word_pack.sv - selects RPW rows of a matrix and packs them into one BRAM word
module mat_word_pack
  import mat_bram_pkg::*;
(
  input  mat_t             I_MAT,
  input  logic [GRP_W-1:0] I_GRP,
  output word_t            O_WORD
);

  // Row RPW*grp+x, column y lands at element index x*COLS+y of the word.
  always_comb begin
    O_WORD = '0;
    for (int x = 0; x < RPW; x++) begin
      for (int y = 0; y < COLS; y++) begin
        O_WORD[(x*COLS+y)*DW +: DW] = I_MAT[RPW*int'(I_GRP) + x][y];
      end
    end
  end

endmodule

// File: rtl/bram_writer.sv
// rtl/bram_writer.sv - stores a captured matrix into four consecutive BRAM words of a slot
module bram_writer
  import mat_bram_pkg::*;
(
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_VLD_PULSE,
  input  logic [SEL_W-1:0]  I_SEL,
  input  mat_t              I_MAT,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic              O_ENA,
  output logic              O_WEA,
  output logic [ADDR_W-1:0] O_ADDRA,
  output word_t             O_DINA
);

  wr_state_t        state_q, state_d;
  mat_t             mat_q, mat_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  word_t            word_d;

  // Next state; a pulse in any state (re)captures the request, aborting a transfer in flight.
  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    sel_d   = sel_q;
    grp_d   = grp_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_WRITE: begin
        if (grp_q == GRP_W'(NGRP-1)) state_d = S_DONE;
        else                         grp_d   = grp_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (I_VLD_PULSE) begin
      state_d = S_WRITE;
      mat_d   = I_MAT;
      sel_d   = I_SEL;
      grp_d   = '0;
    end
  end

  // Packing is fed from next-state values so the registered port shows the word of the coming cycle.
  mat_word_pack u_pack (
    .I_MAT  (mat_d),
    .I_GRP  (grp_d),
    .O_WORD (word_d)
  );

  // State, shadow copies and registered BRAM port; address/data hold while no write is issued.
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      state_q <= S_IDLE;
      mat_q   <= '0;
      sel_q   <= '0;
      grp_q   <= '0;
      O_BUSY  <= 1'b0;
      O_DONE  <= 1'b0;
      O_ENA   <= 1'b0;
      O_WEA   <= 1'b0;
      O_ADDRA <= '0;
      O_DINA  <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      sel_q   <= sel_d;
      grp_q   <= grp_d;
      O_BUSY  <= (state_d == S_WRITE);
      O_ENA   <= (state_d == S_WRITE);
      O_WEA   <= (state_d == S_WRITE);
      O_DONE  <= (state_d == S_DONE);
      if (state_d == S_WRITE) begin
        O_ADDRA <= word_addr(sel_d, grp_d);
        O_DINA  <= word_d;
      end
    end
  end

endmodule

// File: tb/tb_bram_writer.sv
// tb/tb_bram_writer.sv - randomized self-checking bench for bram_writer against a cycle-count model
module tb_bram_writer;
  import mat_bram_pkg::*;

  logic              I_CLK;
  logic              I_RST_N;
  logic              I_VLD_PULSE;
  logic [SEL_W-1:0]  I_SEL;
  mat_t              I_MAT;
  logic              O_BUSY;
  logic              O_DONE;
  logic              O_ENA;
  logic              O_WEA;
  logic [ADDR_W-1:0] O_ADDRA;
  word_t             O_DINA;

  bram_writer dut (
    .I_CLK       (I_CLK),
    .I_RST_N     (I_RST_N),
    .I_VLD_PULSE (I_VLD_PULSE),
    .I_SEL       (I_SEL),
    .I_MAT       (I_MAT),
    .O_BUSY      (O_BUSY),
    .O_DONE      (O_DONE),
    .O_ENA       (O_ENA),
    .O_WEA       (O_WEA),
    .O_ADDRA     (O_ADDRA),
    .O_DINA      (O_DINA)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  int checks   = 0;
  int failures = 0;

  // Model: m_k counts cycles since the last accepted pulse (1..4 write word k-1, 5 done, 0 idle).
  bit         m_valid = 1'b0;
  bit         m_zero  = 1'b0;
  int         m_k     = 0;
  int         m_sel   = 0;
  logic [7:0] snap [0:ROWS-1][0:COLS-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_word(input string nm, input word_t act, input word_t exp);
    int first;
    checks++;
    if (act !== exp) begin
      failures++;
      first = -1;
      for (int i = 0; i < WORD_W/8; i++)
        if (first < 0 && act[i*8 +: 8] !== exp[i*8 +: 8]) first = i;
      $display("FAIL %s byte=%0d actual=%0h required=%0h t=%0t", nm, first,
               act[first*8 +: 8], exp[first*8 +: 8], $time);
    end
  endtask

  // Model update on the same edge the DUT samples its inputs.
  initial begin
    forever begin
      @(posedge I_CLK);
      if (!I_RST_N) begin
        m_valid = 1'b1;
        m_zero  = 1'b1;
        m_k     = 0;
      end else if (I_VLD_PULSE) begin
        m_k    = 1;
        m_sel  = int'(I_SEL);
        m_zero = 1'b0;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            snap[r][c] = I_MAT[r][c];
      end else if (m_k > 0) begin
        m_k = (m_k == 5) ? 0 : m_k + 1;
      end
    end
  end

  // Compare every cycle at the falling edge.
  initial begin : cmp
    word_t ew;
    bit    wr;
    forever begin
      @(negedge I_CLK);
      if (m_valid) begin
        wr = (m_k >= 1 && m_k <= 4);
        chk("ena",  64'(O_ENA),  64'(wr));
        chk("wea",  64'(O_WEA),  64'(wr));
        chk("busy", 64'(O_BUSY), 64'(wr));
        chk("done", 64'(O_DONE), 64'(m_k == 5));
        if (wr) begin
          chk("addra", 64'(O_ADDRA), 64'(m_sel*4 + m_k - 1));
          ew = '0;
          for (int x = 0; x < 4; x++)
            for (int y = 0; y < COLS; y++)
              ew[(x*COLS+y)*8 +: 8] = snap[4*(m_k-1) + x][y];
          chk_word("dina", O_DINA, ew);
        end else if (m_zero) begin
          chk("addra_rst", 64'(O_ADDRA), 64'd0);
          chk_word("dina_rst", O_DINA, '0);
        end
      end
    end
  end

  task automatic nxt();
    @(negedge I_CLK);
  endtask

  task automatic rand_mat();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        I_MAT[r][c] = 8'($urandom);
  endtask

  task automatic set_pattern();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        I_MAT[r][c] = 8'((r*COLS + c) % 256);
  endtask

  task automatic drive_pulse(input logic [SEL_W-1:0] s, input bit pat);
    I_VLD_PULSE = 1'b1;
    I_SEL       = s;
    if (pat) set_pattern();
    else     rand_mat();
  endtask

  task automatic drive_idle();
    I_VLD_PULSE = 1'b0;
    I_SEL       = SEL_W'($urandom);
    rand_mat();
  endtask

  int dcnt;

  initial begin
    I_RST_N     = 1'b0;
    I_VLD_PULSE = 1'b0;
    I_SEL       = '0;
    I_MAT       = '0;
    repeat (3) nxt();
    I_RST_N = 1'b1;
    chk("rst_addra", 64'(O_ADDRA), 64'd0);
    chk("rst_busy",  64'(O_BUSY),  64'd0);
    nxt();

    // Basic write, slot 5, MAT[r][c] = (r*128+c) mod 256; inputs scrambled after the pulse.
    drive_pulse(6'd5, 1'b1);
    nxt(); drive_idle(); chk("basic_addr0", 64'(O_ADDRA), 64'h014);
    nxt(); drive_idle(); chk("basic_addr1", 64'(O_ADDRA), 64'h015);
    chk("basic_w1_b0", 64'(O_DINA[7:0]),  64'h00);
    chk("basic_w1_b1", 64'(O_DINA[15:8]), 64'h01);
    nxt(); drive_idle();
    nxt(); drive_idle(); chk("basic_addr3", 64'(O_ADDRA), 64'h017);
    nxt(); drive_idle(); chk("basic_done",  64'(O_DONE),  64'd1);
    nxt(); chk("basic_done_once", 64'(O_DONE), 64'd0);

    // Top slot: last word lands at 0x0FF.
    drive_pulse(6'd63, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      nxt(); drive_idle();
      if (i == 4) chk("slot63_addr", 64'(O_ADDRA), 64'h0FF);
    end

    // Restart during write: one word of slot 2, then all of slot 9, one done.
    drive_pulse(6'd2, 1'b0);
    dcnt = 0;
    nxt(); chk("restart_first", 64'(O_ADDRA), 64'h008); drive_pulse(6'd9, 1'b0);
    for (int i = 2; i <= 9; i++) begin
      nxt();
      if (i == 2) chk("restart_addr0", 64'(O_ADDRA), 64'h024);
      if (i == 5) chk("restart_addr3", 64'(O_ADDRA), 64'h027);
      if (i == 6) chk("restart_done",  64'(O_DONE),  64'd1);
      dcnt += int'(O_DONE);
      drive_idle();
    end
    chk("restart_done_count", 64'(dcnt), 64'd1);

    // Back-to-back: new pulse in the done cycle is accepted.
    drive_pulse(6'd12, 1'b0);
    dcnt = 0;
    for (int i = 1; i <= 11; i++) begin
      nxt();
      dcnt += int'(O_DONE);
      if (i == 5) begin
        chk("b2b_done1", 64'(O_DONE), 64'd1);
        drive_pulse(6'd20, 1'b0);
      end else begin
        if (i == 6) chk("b2b_addr", 64'(O_ADDRA), 64'h050);
        drive_idle();
      end
    end
    chk("b2b_done_count", 64'(dcnt), 64'd2);

    // Reset mid-transfer.
    drive_pulse(6'd33, 1'b0);
    nxt(); drive_idle();
    nxt(); drive_idle();
    nxt(); drive_idle(); I_RST_N = 1'b0;
    nxt();
    chk("midrst_ena",   64'(O_ENA),   64'd0);
    chk("midrst_done",  64'(O_DONE),  64'd0);
    chk("midrst_addra", 64'(O_ADDRA), 64'd0);
    I_RST_N = 1'b1; drive_idle();
    dcnt = 0;
    repeat (8) begin
      nxt();
      dcnt += int'(O_DONE) + int'(O_ENA);
      drive_idle();
    end
    chk("midrst_quiet", 64'(dcnt), 64'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      nxt();
      I_RST_N     = ($urandom_range(0, 49) != 0);
      I_VLD_PULSE = ($urandom_range(0, 5) == 0);
      I_SEL       = SEL_W'($urandom);
      rand_mat();
    end
    nxt();
    I_RST_N     = 1'b1;
    I_VLD_PULSE = 1'b0;
    repeat (8) nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
